branch_feedback_queue: RTL and testbench

//  In-order tracker of in-flight predicted branches; the producer side of the gselect predictor's feedback port.

---
 rtl/mips_core_pkg.sv | 20 ++
 rtl/branch_fb_fifo.sv | 59 +++++
 rtl/branch_feedback_queue.sv | 80 ++++++++
 tb/tb_branch_feedback_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and the branch feedback queue entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int BRANCH_FB_DEPTH = 8;

    typedef struct packed {
        logic [`ADDR_WIDTH-1:0] pc;
        BranchOutcome           pred;
    } BranchFbEntry;

endpackage

// File: rtl/branch_fb_fifo.sv
// Circular buffer of in-flight branch entries; clr discards everything behind
// the (possibly advancing) head in the same edge.
module branch_fb_fifo
    import mips_core_pkg::*;
#(
    parameter int DEPTH = BRANCH_FB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  BranchFbEntry       push_data,
    input  logic               pop,
    input  logic               clr,
    output BranchFbEntry       head_data,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    BranchFbEntry     mem [DEPTH];
    logic [PTR_W-1:0] head, tail, head_nxt;

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    assign head_nxt  = pop ? head + 1'b1 : head;
    assign head_data = mem[head];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_nxt;
            if (clr) begin
                tail  <= head_nxt;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[tail] <= push_data;
    end

endmodule

// File: rtl/branch_feedback_queue.sv
// In-order tracker of predicted branches; pops on resolution and drives the
// predictor feedback port one cycle later, discarding wrong-path entries.
module branch_feedback_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = BRANCH_FB_DEPTH,
    parameter int ADDR_W = `ADDR_WIDTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push_valid,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  BranchOutcome      i_push_prediction,
    output logic              o_full,
    input  logic              i_res_valid,
    input  logic [ADDR_W-1:0] i_res_pc,
    input  BranchOutcome      i_res_outcome,
    input  logic              i_flush,
    output logic              o_fb_valid,
    output logic [ADDR_W-1:0] o_fb_pc,
    output BranchOutcome      o_fb_prediction,
    output BranchOutcome      o_fb_outcome,
    output logic              o_mispredict,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_err
);

    BranchFbEntry head, push_data;
    logic         full, empty;
    logic         pop, mis, push_ok, clr, err_set;

    assign pop       = i_res_valid && !empty;
    assign mis       = pop && (head.pred != i_res_outcome);
    // A full queue can still accept when the head leaves on a correct prediction.
    assign push_ok   = i_push_valid && !i_flush && !mis && (!full || pop);
    assign clr       = i_flush || mis;
    assign push_data = '{pc: i_push_pc, pred: i_push_prediction};

    assign err_set = (i_push_valid && full && !pop)
                   || (i_res_valid && empty)
                   || (pop && (i_res_pc != head.pc));

    branch_fb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .clr       (clr),
        .head_data (head),
        .count     (o_count),
        .full      (full),
        .empty     (empty)
    );

    assign o_full = full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fb_valid      <= 1'b0;
            o_fb_pc         <= '0;
            o_fb_prediction <= NOT_TAKEN;
            o_fb_outcome    <= NOT_TAKEN;
            o_mispredict    <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            o_fb_valid   <= pop;
            o_mispredict <= mis;
            if (pop) begin
                o_fb_pc         <= head.pc;
                o_fb_prediction <= head.pred;
                o_fb_outcome    <= i_res_outcome;
            end
            if (err_set)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue: per-cycle vector table plus
// hand-written async-reset sequences.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_feedback_queue;
    import mips_core_pkg::*;

    localparam int AW = `ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_push_valid = 1'b0;
    logic [AW-1:0] i_push_pc = '0;
    BranchOutcome  i_push_prediction = NOT_TAKEN;
    logic          o_full;
    logic          i_res_valid = 1'b0;
    logic [AW-1:0] i_res_pc = '0;
    BranchOutcome  i_res_outcome = NOT_TAKEN;
    logic          i_flush = 1'b0;
    logic          o_fb_valid;
    logic [AW-1:0] o_fb_pc;
    BranchOutcome  o_fb_prediction;
    BranchOutcome  o_fb_outcome;
    logic          o_mispredict;
    logic [3:0]    o_count;
    logic          o_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_feedback_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_push_valid      (i_push_valid),
        .i_push_pc         (i_push_pc),
        .i_push_prediction (i_push_prediction),
        .o_full            (o_full),
        .i_res_valid       (i_res_valid),
        .i_res_pc          (i_res_pc),
        .i_res_outcome     (i_res_outcome),
        .i_flush           (i_flush),
        .o_fb_valid        (o_fb_valid),
        .o_fb_pc           (o_fb_pc),
        .o_fb_prediction   (o_fb_prediction),
        .o_fb_outcome      (o_fb_outcome),
        .o_mispredict      (o_mispredict),
        .o_count           (o_count),
        .o_err             (o_err)
    );

    typedef struct {
        bit            rst;
        bit            pv;
        logic [AW-1:0] ppc;
        bit            ppred;
        bit            rv;
        logic [AW-1:0] rpc;
        bit            rout;
        bit            fl;
        bit            ev;
        logic [AW-1:0] epc;
        bit            epred;
        bit            eout;
        bit            emis;
        int            ecnt;
        bit            efull;
        bit            eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit pv, int ppc, bit ppred, bit rv, int rpc, bit rout,
                                bit fl, bit ev, int epc, bit epred, bit eout, bit emis,
                                int ecnt, bit efull, bit eerr);
        vec_t v;
        v.rst = rst; v.pv = pv; v.ppc = AW'(ppc); v.ppred = ppred;
        v.rv = rv; v.rpc = AW'(rpc); v.rout = rout; v.fl = fl;
        v.ev = ev; v.epc = AW'(epc); v.epred = epred; v.eout = eout; v.emis = emis;
        v.ecnt = ecnt; v.efull = efull; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(string nm, int row, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(int row, bit ev, int epc, bit epred, bit eout, bit emis,
                           int ecnt, bit efull, bit eerr);
        chk("fb_valid", row, 64'(o_fb_valid), 64'(ev));
        chk("fb_pc", row, 64'(o_fb_pc), 64'(epc));
        chk("fb_pred", row, 64'(o_fb_prediction == TAKEN), 64'(epred));
        chk("fb_out", row, 64'(o_fb_outcome == TAKEN), 64'(eout));
        chk("mispredict", row, 64'(o_mispredict), 64'(emis));
        chk("count", row, 64'(o_count), 64'(ecnt));
        chk("full", row, 64'(o_full), 64'(efull));
        chk("err", row, 64'(o_err), 64'(eerr));
    endtask

    task automatic idle_inputs();
        i_push_valid = 1'b0;
        i_res_valid  = 1'b0;
        i_flush      = 1'b0;
    endtask

    initial begin
        // 1 = TAKEN, 0 = NOT_TAKEN
        //            rst pv ppc    pp rv rpc    ro fl  ev epc    ep eo mis cnt full err
        // in-order resolve, both correct
        vecs.push_back(mk(0, 1, 'h100, 1, 0, 0,     0, 0,  0, 0,     0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 'h104, 0, 0, 0,     0, 0,  0, 0,     0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 'h100, 1, 0,  1, 'h100, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 'h104, 0, 0,  1, 'h104, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 'h104, 0, 0, 0, 0, 0, 0));
        // mispredict squashes younger entries and the same-cycle push
        vecs.push_back(mk(0, 1, 'h200, 1, 0, 0,     0, 0,  0, 'h104, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 'h204, 0, 0, 0,     0, 0,  0, 'h104, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 'h208, 1, 0, 0,     0, 0,  0, 'h104, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 'h20C, 1, 1, 'h200, 0, 0,  1, 'h200, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 'h200, 1, 0, 0, 0, 0, 0));
        // fill to full (head starts mid-array, so this wraps)
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 'h400 + 4*i, (i % 2) == 0, 0, 0, 0, 0,
                              0, 'h200, 1, 0, 0, i + 1, i == 7, 0));
        vecs.push_back(mk(0, 1, 'h500, 1, 0, 0,     0, 0,  0, 'h200, 1, 0, 0, 8, 1, 1));
        vecs.push_back(mk(0, 1, 'h420, 1, 1, 'h400, 1, 0,  1, 'h400, 1, 1, 0, 8, 1, 1));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 'h400 + 4*k, (k % 2) == 0, 0,
                              1, 'h400 + 4*k, (k % 2) == 0, (k % 2) == 0, 0, 8 - k, 0, 1));
        vecs.push_back(mk(0, 0, 0,     0, 1, 'h420, 1, 0,  1, 'h420, 1, 1, 0, 0, 0, 1));
        // resolve on empty; PC mismatch
        vecs.push_back(mk(1, 0, 0,     0, 1, 'h300, 0, 0,  0, 0,     0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 'h304, 1, 0, 0,     0, 0,  0, 0,     0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 'h300, 1, 0,  1, 'h304, 1, 1, 0, 0, 0, 1));
        // flush with a same-cycle resolve and push
        vecs.push_back(mk(1, 1, 'h600, 1, 0, 0,     0, 0,  0, 0,     0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 'h604, 0, 0, 0,     0, 0,  0, 0,     0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 'h608, 1, 0, 0,     0, 0,  0, 0,     0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 'h60C, 0, 1, 'h600, 1, 1,  1, 'h600, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 'h600, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h610, 1, 0, 0,     0, 0,  0, 'h600, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 'h610, 0, 0,  1, 'h610, 1, 0, 1, 0, 0, 0));

        // reset state
        #12;
        chk_all(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[r]) begin
            if (vecs[r].rst) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                #1;
            end
            i_push_valid      = vecs[r].pv;
            i_push_pc         = vecs[r].ppc;
            i_push_prediction = BranchOutcome'(vecs[r].ppred);
            i_res_valid       = vecs[r].rv;
            i_res_pc          = vecs[r].rpc;
            i_res_outcome     = BranchOutcome'(vecs[r].rout);
            i_flush           = vecs[r].fl;
            @(posedge clk);
            #1;
            chk_all(r, vecs[r].ev, int'(vecs[r].epc), vecs[r].epred, vecs[r].eout,
                    vecs[r].emis, vecs[r].ecnt, vecs[r].efull, vecs[r].eerr);
        end
        idle_inputs();

        // async reset while feedback is being presented
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        i_push_valid = 1'b1; i_push_pc = AW'('h700); i_push_prediction = TAKEN;
        @(posedge clk); #1;
        i_push_valid = 1'b0;
        i_res_valid = 1'b1; i_res_pc = AW'('h700); i_res_outcome = NOT_TAKEN;
        @(posedge clk); #1;
        chk("pre_rst_fb_valid", 100, 64'(o_fb_valid), 64'(1));
        chk("pre_rst_mis", 100, 64'(o_mispredict), 64'(1));
        i_res_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_all(101, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // async reset with a pop pending at the next edge
        i_push_valid = 1'b1; i_push_pc = AW'('h704); i_push_prediction = TAKEN;
        @(posedge clk); #1;
        i_push_valid = 1'b0;
        chk("pending_count", 102, 64'(o_count), 64'(1));
        i_res_valid = 1'b1; i_res_pc = AW'('h704); i_res_outcome = TAKEN;
        #2 rst_n = 1'b0;
        #1;
        chk_all(103, 0, 0, 0, 0, 0, 0, 0, 0);
        i_res_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_fb", 104 + c, 64'(o_fb_valid), 64'(0));
            chk("post_rst_count", 104 + c, 64'(o_count), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
